// File: rtl/traffic_phase_ctrl.sv
// Intersection phase controller: one main road plus NUM_SIDE side approaches, built-in tick-driven phase timer.
// Latency: a phase change and its lamp update are visible in the cycle after timer expiry (Tick while count==0).
// Backpressure: none; requests are latched and served round-robin. Optional ALL_RED_EN adds an all-red clearance phase.
module traffic_phase_ctrl #(
  parameter int NUM_SIDE = 3,
  parameter int CNT_W    = 8,
  parameter int T_BASE   = 4,
  parameter int T_EXT    = 2,
  parameter int T_YEL    = 1
) (
  input  logic                                              clk,
  input  logic                                              Reset_n,
  input  logic                                              Tick,
  input  logic                                              Prog_Sync,
  input  logic [NUM_SIDE-1:0]                               Sensor_Sync,
  input  logic                                              WR_Sync,
  output logic [2:0]                                        Main_LEDs,
  output logic [3*NUM_SIDE-1:0]                             Side_LEDs,
  output logic                                              Walk,
  output logic [((NUM_SIDE > 1) ? $clog2(NUM_SIDE) : 1)-1:0] Active_Side,
  output logic [2:0]                                        Phase
);

  localparam int SW = (NUM_SIDE > 1) ? $clog2(NUM_SIDE) : 1;

  localparam logic [CNT_W-1:0] LD_INIT = CNT_W'(2*T_BASE-1);
  localparam logic [CNT_W-1:0] LD_BASE = CNT_W'(T_BASE-1);
  localparam logic [CNT_W-1:0] LD_EXT  = CNT_W'(T_EXT-1);
  localparam logic [CNT_W-1:0] LD_YEL  = CNT_W'(T_YEL-1);
  localparam logic [SW-1:0]    ACT_RST = SW'(NUM_SIDE-1);

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef enum logic [2:0] {
    MAIN_GRN = 3'd0,
    MAIN_YEL = 3'd1,
    WALK     = 3'd2,
    SIDE_GRN = 3'd3,
    SIDE_YEL = 3'd4
`ifdef ALL_RED_EN
    ,
    ALL_RED  = 3'd5
`endif
  } state_t;

  state_t              st_q, st_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [SW-1:0]       act_q, act_n;
  logic [NUM_SIDE-1:0] dem_q, dem_n;
  logic                wlk_q, wlk_n;
  logic                mext_q, mext_n;   // main-green one-shot extension still available
  logic                sext_q, sext_n;   // side-green one-shot extension still available
`ifdef ALL_RED_EN
  logic                arm_q, arm_n;     // 1: all-red follows main yellow, 0: follows side yellow
`endif

  logic                expire;
  logic                any_dem;
  logic [SW-1:0]       pick;
  logic [SW-1:0]       cand;
  logic                hit;
  logic                go_main, go_side, go_walk, go_after_my, go_rst;

  assign expire      = Tick && (cnt_q == '0);
  assign any_dem     = |dem_q;
  assign Phase       = st_q;
  assign Active_Side = act_q;

  // Main road lamps for a given phase.
  function automatic logic [2:0] main_lamps(input state_t s);
    logic [2:0] v;
    case (s)
      MAIN_GRN: v = LAMP_G;
      MAIN_YEL: v = LAMP_Y;
      default:  v = LAMP_R;
    endcase
    return v;
  endfunction

  // Side lamps: only the active side can be non-red, and only in its own phases.
  function automatic logic [3*NUM_SIDE-1:0] side_lamps(input state_t s, input logic [SW-1:0] a);
    logic [3*NUM_SIDE-1:0] v;
    v = {NUM_SIDE{LAMP_R}};
    for (int i = 0; i < NUM_SIDE; i++) begin
      if (SW'(i) == a) begin
        if (s == SIDE_GRN) begin
          v[3*i +: 3] = LAMP_G;
        end else if (s == SIDE_YEL) begin
          v[3*i +: 3] = LAMP_Y;
        end
      end
    end
    return v;
  endfunction

  // Round-robin pick: first latched demand after the last served side, wrapping.
  always_comb begin
    pick = act_q;
    hit  = 1'b0;
    cand = '0;
    for (int k = 1; k <= NUM_SIDE; k++) begin
      cand = SW'((int'(act_q) + k) % NUM_SIDE);
      if (!hit && dem_q[cand]) begin
        hit  = 1'b1;
        pick = cand;
      end
    end
  end

  // Next-state, timer and latch logic; phase entries are applied after the per-state decision.
  always_comb begin
    st_n        = st_q;
    cnt_n       = cnt_q;
    act_n       = act_q;
    dem_n       = dem_q | Sensor_Sync;
    // A walk request arriving while walk is already showing is dropped.
    wlk_n       = wlk_q | (WR_Sync & (st_q != WALK));
    mext_n      = mext_q;
    sext_n      = sext_q;
`ifdef ALL_RED_EN
    arm_n       = arm_q;
`endif
    go_main     = 1'b0;
    go_side     = 1'b0;
    go_walk     = 1'b0;
    go_after_my = 1'b0;
    go_rst      = 1'b0;

    if (Tick && (cnt_q != '0)) begin
      cnt_n = cnt_q - CNT_W'(1);
    end

    case (st_q)
      MAIN_GRN: begin
        if (expire) begin
          if (mext_q && any_dem) begin
            cnt_n  = LD_EXT;
            mext_n = 1'b0;
          end else if (any_dem || wlk_q) begin
            st_n  = MAIN_YEL;
            cnt_n = LD_YEL;
          end else begin
            // Idle road: keep main green, extension stays armed.
            cnt_n = LD_BASE;
          end
        end
      end
      MAIN_YEL: begin
        if (expire) begin
`ifdef ALL_RED_EN
          st_n  = ALL_RED;
          cnt_n = '0;
          arm_n = 1'b1;
`else
          go_after_my = 1'b1;
`endif
        end
      end
      WALK: begin
        if (expire) begin
          if (any_dem) begin
            go_side = 1'b1;
          end else begin
            go_main = 1'b1;
          end
        end
      end
      SIDE_GRN: begin
        if (expire) begin
          if (sext_q && Sensor_Sync[act_q]) begin
            cnt_n  = LD_EXT;
            sext_n = 1'b0;
          end else begin
            st_n  = SIDE_YEL;
            cnt_n = LD_YEL;
          end
        end
      end
      SIDE_YEL: begin
        if (expire) begin
`ifdef ALL_RED_EN
          st_n  = ALL_RED;
          cnt_n = '0;
          arm_n = 1'b0;
`else
          go_main = 1'b1;
`endif
        end
      end
`ifdef ALL_RED_EN
      ALL_RED: begin
        if (expire) begin
          if (arm_q) begin
            go_after_my = 1'b1;
          end else begin
            go_main = 1'b1;
          end
        end
      end
`endif
      default: go_rst = 1'b1;
    endcase

    // After main yellow: walk has precedence over side service.
    if (go_after_my) begin
      if (wlk_q) begin
        go_walk = 1'b1;
      end else if (any_dem) begin
        go_side = 1'b1;
      end else begin
        go_main = 1'b1;
      end
    end

    if (go_walk) begin
      st_n  = WALK;
      cnt_n = LD_EXT;
      wlk_n = 1'b0;
    end
    if (go_side) begin
      st_n        = SIDE_GRN;
      cnt_n       = LD_BASE;
      act_n       = pick;
      dem_n[pick] = 1'b0;
      sext_n      = 1'b1;
    end
    if (go_main) begin
      st_n   = MAIN_GRN;
      cnt_n  = LD_BASE;
      mext_n = 1'b1;
    end

    // Synchronous restart and illegal-code recovery override everything.
    if (go_rst || Prog_Sync) begin
      st_n   = MAIN_GRN;
      cnt_n  = LD_INIT;
      act_n  = ACT_RST;
      dem_n  = '0;
      wlk_n  = 1'b0;
      mext_n = 1'b1;
      sext_n = 1'b1;
`ifdef ALL_RED_EN
      arm_n  = 1'b0;
`endif
    end
  end

  // Phase state, timer, latches and registered lamp outputs.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      st_q      <= MAIN_GRN;
      cnt_q     <= LD_INIT;
      act_q     <= ACT_RST;
      dem_q     <= '0;
      wlk_q     <= 1'b0;
      mext_q    <= 1'b1;
      sext_q    <= 1'b1;
`ifdef ALL_RED_EN
      arm_q     <= 1'b0;
`endif
      Main_LEDs <= LAMP_G;
      Side_LEDs <= {NUM_SIDE{LAMP_R}};
      Walk      <= 1'b0;
    end else begin
      st_q      <= st_n;
      cnt_q     <= cnt_n;
      act_q     <= act_n;
      dem_q     <= dem_n;
      wlk_q     <= wlk_n;
      mext_q    <= mext_n;
      sext_q    <= sext_n;
`ifdef ALL_RED_EN
      arm_q     <= arm_n;
`endif
      Main_LEDs <= main_lamps(st_n);
      Side_LEDs <= side_lamps(st_n, act_n);
      Walk      <= (st_n == WALK);
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with default parameters (3 sides, T_BASE=4, T_EXT=2, T_YEL=1).
// Table rows hold inputs for ncyc clocks, then compare all outputs; corner cases are hand-written sequences.
`timescale 1ns/1ps
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       Reset_n;
  logic       Tick;
  logic       Prog_Sync;
  logic [2:0] Sensor_Sync;
  logic       WR_Sync;
  logic [2:0] Main_LEDs;
  logic [8:0] Side_LEDs;
  logic       Walk;
  logic [1:0] Active_Side;
  logic [2:0] Phase;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;
  localparam logic [8:0] SR  = 9'b100_100_100;
  localparam logic [8:0] S0G = 9'b100_100_001;
  localparam logic [8:0] S0Y = 9'b100_100_010;
  localparam logic [8:0] S1G = 9'b100_001_100;
  localparam logic [8:0] S1Y = 9'b100_010_100;
  localparam logic [8:0] S2G = 9'b001_100_100;
  localparam logic [8:0] S2Y = 9'b010_100_100;

  traffic_phase_ctrl dut (
    .clk         (clk),
    .Reset_n     (Reset_n),
    .Tick        (Tick),
    .Prog_Sync   (Prog_Sync),
    .Sensor_Sync (Sensor_Sync),
    .WR_Sync     (WR_Sync),
    .Main_LEDs   (Main_LEDs),
    .Side_LEDs   (Side_LEDs),
    .Walk        (Walk),
    .Active_Side (Active_Side),
    .Phase       (Phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tick;
    logic       prog;
    logic       wr;
    logic [2:0] sens;
    int         ncyc;
    logic [2:0] ph;
    logic [2:0] mn;
    logic [8:0] sd;
    logic       wk;
    logic [1:0] ac;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic tk, input logic pg, input logic wr, input logic [2:0] sn,
                              input int n, input logic [2:0] ph, input logic [2:0] mn,
                              input logic [8:0] sd, input logic wk, input logic [1:0] ac);
    vec_t v;
    v.tick = tk; v.prog = pg; v.wr = wr; v.sens = sn; v.ncyc = n;
    v.ph = ph; v.mn = mn; v.sd = sd; v.wk = wk; v.ac = ac;
    return v;
  endfunction

  task automatic check(input string nm, input logic [2:0] ph, input logic [2:0] mn,
                       input logic [8:0] sd, input logic wk, input logic [1:0] ac);
    logic [16:0] got;
    logic [16:0] exp;
    got = {Phase, Main_LEDs, Side_LEDs, Walk, Active_Side};
    exp = {ph, mn, sd, wk, ac};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got ph=%0d main=%b side=%b walk=%b act=%0d, want ph=%0d main=%b side=%b walk=%b act=%0d",
               nm, Phase, Main_LEDs, Side_LEDs, Walk, Active_Side, ph, mn, sd, wk, ac);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

`ifdef ALL_RED_EN
  logic [2:0] ar_seq [9] = '{3'd1, 3'd5, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd5, 3'd0};
`endif

  initial begin
    Reset_n = 1'b0; Tick = 1'b0; Prog_Sync = 1'b0; Sensor_Sync = '0; WR_Sync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 3'd0, G, SR, 1'b0, 2'd2);
    Reset_n = 1'b1;

`ifdef ALL_RED_EN
    // Side 0 request: main G, Y, all-red, side G, side Y, all-red, main G.
    Tick = 1'b1; Sensor_Sync = 3'b001;
    step(1);
    Sensor_Sync = '0;
    step(8);
    check("ar_pre", 3'd0, G, SR, 1'b0, 2'd2);
    for (int i = 0; i < 9; i++) begin
      step(1);
      total++;
      if (Phase !== ar_seq[i]) begin
        bad++;
        $display("FAIL ar_seq%0d: got phase=%0d want %0d", i, Phase, ar_seq[i]);
      end
    end
`else
    // Idle road: lamps never change.
    vq.push_back(mk(1,0,0,3'b000,20, 3'd0,G,SR,0,2'd2));
    // Side 1 pulse: extended main, yellow, side 1 for 4 ticks, back to main.
    vq.push_back(mk(1,1,0,3'b000,1,  3'd0,G,SR,0,2'd2));
    vq.push_back(mk(1,0,0,3'b010,1,  3'd0,G,SR,0,2'd2));
    vq.push_back(mk(1,0,0,3'b000,8,  3'd0,G,SR,0,2'd2));
    vq.push_back(mk(1,0,0,3'b000,1,  3'd1,Y,SR,0,2'd2));
    vq.push_back(mk(1,0,0,3'b000,1,  3'd3,R,S1G,0,2'd1));
    vq.push_back(mk(1,0,0,3'b000,3,  3'd3,R,S1G,0,2'd1));
    vq.push_back(mk(1,0,0,3'b000,1,  3'd4,R,S1Y,0,2'd1));
    vq.push_back(mk(1,0,0,3'b000,1,  3'd0,G,SR,0,2'd1));
    // Sides 0 and 2 held: served 0,2,0,2 with one extension each.
    vq.push_back(mk(1,1,0,3'b000,1,  3'd0,G,SR,0,2'd2));
    vq.push_back(mk(1,0,0,3'b101,10, 3'd1,Y,SR,0,2'd2));
    vq.push_back(mk(1,0,0,3'b101,1,  3'd3,R,S0G,0,2'd0));
    vq.push_back(mk(1,0,0,3'b101,5,  3'd3,R,S0G,0,2'd0));
    vq.push_back(mk(1,0,0,3'b101,1,  3'd4,R,S0Y,0,2'd0));
    vq.push_back(mk(1,0,0,3'b101,1,  3'd0,G,SR,0,2'd0));
    vq.push_back(mk(1,0,0,3'b101,6,  3'd1,Y,SR,0,2'd0));
    vq.push_back(mk(1,0,0,3'b101,1,  3'd3,R,S2G,0,2'd2));
    vq.push_back(mk(1,0,0,3'b101,6,  3'd4,R,S2Y,0,2'd2));
    vq.push_back(mk(1,0,0,3'b101,1,  3'd0,G,SR,0,2'd2));
    vq.push_back(mk(1,0,0,3'b101,7,  3'd3,R,S0G,0,2'd0));
    vq.push_back(mk(1,0,0,3'b101,7,  3'd0,G,SR,0,2'd0));
    vq.push_back(mk(1,0,0,3'b101,7,  3'd3,R,S2G,0,2'd2));
    // Walk plus side 2: walk phase first; a walk request during walk is dropped.
    vq.push_back(mk(1,1,0,3'b000,1,  3'd0,G,SR,0,2'd2));
    vq.push_back(mk(1,0,1,3'b100,1,  3'd0,G,SR,0,2'd2));
    vq.push_back(mk(1,0,0,3'b000,9,  3'd1,Y,SR,0,2'd2));
    vq.push_back(mk(1,0,0,3'b000,1,  3'd2,R,SR,1,2'd2));
    vq.push_back(mk(1,0,1,3'b000,1,  3'd2,R,SR,1,2'd2));
    vq.push_back(mk(1,0,0,3'b000,1,  3'd3,R,S2G,0,2'd2));
    vq.push_back(mk(1,0,0,3'b000,4,  3'd4,R,S2Y,0,2'd2));
    vq.push_back(mk(1,0,0,3'b000,1,  3'd0,G,SR,0,2'd2));
    vq.push_back(mk(1,0,0,3'b000,12, 3'd0,G,SR,0,2'd2));
    // Prog_Sync on the same cycle as yellow expiry wins and clears demand.
    vq.push_back(mk(1,1,0,3'b000,1,  3'd0,G,SR,0,2'd2));
    vq.push_back(mk(1,0,0,3'b010,1,  3'd0,G,SR,0,2'd2));
    vq.push_back(mk(1,0,0,3'b000,9,  3'd1,Y,SR,0,2'd2));
    vq.push_back(mk(1,1,0,3'b000,1,  3'd0,G,SR,0,2'd2));
    vq.push_back(mk(1,0,0,3'b000,12, 3'd0,G,SR,0,2'd2));
    // No Tick, no progress; timer resumes where it stood.
    vq.push_back(mk(1,1,0,3'b000,1,  3'd0,G,SR,0,2'd2));
    vq.push_back(mk(0,0,0,3'b010,20, 3'd0,G,SR,0,2'd2));
    vq.push_back(mk(1,0,0,3'b000,9,  3'd0,G,SR,0,2'd2));
    vq.push_back(mk(1,0,0,3'b000,1,  3'd1,Y,SR,0,2'd2));

    foreach (vq[i]) begin
      Tick        = vq[i].tick;
      Prog_Sync   = vq[i].prog;
      WR_Sync     = vq[i].wr;
      Sensor_Sync = vq[i].sens;
      step(vq[i].ncyc);
      check($sformatf("row%0d", i), vq[i].ph, vq[i].mn, vq[i].sd, vq[i].wk, vq[i].ac);
    end
    Tick = 1'b1; Prog_Sync = 1'b0; WR_Sync = 1'b0; Sensor_Sync = '0;

    // Async reset in the middle of side 0 green, with side 1 demand pending.
    Prog_Sync = 1'b1;
    step(1);
    Prog_Sync = 1'b0; Sensor_Sync = 3'b001;
    step(1);
    Sensor_Sync = '0;
    step(10);
    check("arst_pre", 3'd3, R, S0G, 1'b0, 2'd0);
    Sensor_Sync = 3'b010;
    step(1);
    Sensor_Sync = '0;
    #3;
    Reset_n = 1'b0;
    #1;
    check("arst_async", 3'd0, G, SR, 1'b0, 2'd2);
    @(posedge clk);
    #1;
    Reset_n = 1'b1;
    step(12);
    check("arst_cleared", 3'd0, G, SR, 1'b0, 2'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
